// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter that merges N_REQ byte streams onto one uart_tx input.
// A grant is held for a whole packet (or until the requester stalls past IDLE_TIMEOUT).
module uart_tx_arbiter #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned IDLE_TIMEOUT = 2700000
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N_REQ-1:0]     i_tvalid,
  output logic [N_REQ-1:0]     i_tready,
  input  logic [8*N_REQ-1:0]   i_tdata,
  input  logic [N_REQ-1:0]     i_tlast,
  output logic                 o_tvalid,
  input  logic                 o_tready,
  output logic [7:0]           o_tdata,
  output logic                 o_tlast,
  output logic                 o_grant_valid,
  output logic [2:0]           o_grant_id,
  output logic                 o_timeout
);

  typedef enum logic [0:0] {StIdle, StXfer} state_e;

  localparam logic [31:0] TimeoutM1 = IDLE_TIMEOUT - 32'd1;

  state_e      r_state, w_state_nxt;
  logic [2:0]  r_gid, w_gid_nxt;
  logic [2:0]  r_last, w_last_nxt;
  logic [31:0] r_cnt, w_cnt_nxt;
  logic        r_tvalid, w_tvalid_nxt;
  logic [7:0]  r_tdata, w_tdata_nxt;
  logic        r_tlast, w_tlast_nxt;
  logic        r_timeout, w_timeout_nxt;

  // Zero-padded to 8 requesters so a 3-bit id indexes them without width games.
  logic [7:0]  w_valid_pad;
  logic [7:0]  w_last_pad;
  logic [63:0] w_data_pad;

  logic        w_load_ok;
  logic        w_sel_valid;
  logic        w_sel_last;
  logic [7:0]  w_sel_data;
  logic        w_accept;
  logic        w_expire;
  logic        w_found;
  logic [2:0]  w_pick;
  logic [3:0]  w_sum;

  assign w_valid_pad = 8'(i_tvalid);
  assign w_last_pad  = 8'(i_tlast);
  assign w_data_pad  = 64'(i_tdata);

  assign w_load_ok   = !r_tvalid || o_tready;
  assign w_sel_valid = w_valid_pad[r_gid];
  assign w_sel_last  = w_last_pad[r_gid];
  assign w_sel_data  = w_data_pad[{r_gid, 3'b000} +: 8];
  assign w_accept    = (r_state == StXfer) && w_sel_valid && w_load_ok;

  // The counter only advances while the granted source itself has nothing to offer.
  assign w_expire = (IDLE_TIMEOUT != 0) && (r_state == StXfer) && !w_sel_valid &&
                    ((r_cnt + 32'd1) >= TimeoutM1);

  // Round-robin search starting just after the previous grant.
  always_comb begin
    w_found = 1'b0;
    w_pick  = 3'd0;
    w_sum   = 4'd0;
    for (int i = 1; i <= int'(N_REQ); i++) begin
      w_sum = {1'b0, r_last} + 4'(i);
      if (w_sum >= 4'(N_REQ)) w_sum = w_sum - 4'(N_REQ);
      if (!w_found && w_valid_pad[w_sum[2:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[2:0];
      end
    end
  end

  always_comb begin
    i_tready = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      i_tready[k] = (r_state == StXfer) && (r_gid == 3'(k)) && w_load_ok;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_gid_nxt     = r_gid;
    w_last_nxt    = r_last;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
    w_tvalid_nxt  = r_tvalid;
    w_tdata_nxt   = r_tdata;
    w_tlast_nxt   = r_tlast;

    if (r_tvalid && o_tready) w_tvalid_nxt = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_state_nxt = StXfer;
          w_gid_nxt   = w_pick;
          w_cnt_nxt   = 32'd0;
        end
      end
      StXfer: begin
        if (w_accept) begin
          w_tvalid_nxt = 1'b1;
          w_tdata_nxt  = w_sel_data;
          w_tlast_nxt  = w_sel_last;
          w_cnt_nxt    = 32'd0;
          if (w_sel_last) begin
            w_state_nxt = StIdle;
            w_last_nxt  = r_gid;
          end
        end else if (!w_sel_valid) begin
          if (w_expire) begin
            w_state_nxt   = StIdle;
            w_last_nxt    = r_gid;
            w_timeout_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 32'd1;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= StIdle;
      r_gid     <= 3'd0;
      r_last    <= 3'(N_REQ - 1);
      r_cnt     <= 32'd0;
      r_tvalid  <= 1'b0;
      r_tdata   <= 8'd0;
      r_tlast   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gid     <= w_gid_nxt;
      r_last    <= w_last_nxt;
      r_cnt     <= w_cnt_nxt;
      r_tvalid  <= w_tvalid_nxt;
      r_tdata   <= w_tdata_nxt;
      r_tlast   <= w_tlast_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign o_tvalid      = r_tvalid;
  assign o_tdata       = r_tdata;
  assign o_tlast       = r_tlast;
  assign o_grant_valid = (r_state == StXfer);
  assign o_grant_id    = r_gid;
  assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte sources, an output scoreboard and grant log,
// a cycle table for the single-packet case and directed sequences for the multi-cycle cases.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rstn;
  logic [N-1:0]   tv, trdy, tl;
  logic [8*N-1:0] td;
  logic           ovalid, ordy, olast, ogv, oto;
  logic [7:0]     odata;
  logic [2:0]     ogid;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .IDLE_TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .i_tvalid(tv), .i_tready(trdy), .i_tdata(td), .i_tlast(tl),
    .o_tvalid(ovalid), .o_tready(ordy), .o_tdata(odata), .o_tlast(olast),
    .o_grant_valid(ogv), .o_grant_id(ogid), .o_timeout(oto)
  );

  // Source FIFOs: {tlast, byte}; a byte leaves only on an observed handshake.
  logic [8:0] src_mem [N][64];
  int         src_wr [N];
  int         src_rd [N];

  always_comb begin
    tv = '0;
    td = '0;
    tl = '0;
    for (int k = 0; k < N; k++) begin
      if (src_rd[k] < src_wr[k]) begin
        tv[k]          = 1'b1;
        td[8*k +: 8]   = src_mem[k][src_rd[k] % 64][7:0];
        tl[k]          = src_mem[k][src_rd[k] % 64][8];
      end
    end
  end

  logic [8:0] exp_q[$];
  int         grant_log[$];
  int         n_cmp, n_fail;
  int         cyc, to_cnt, to_cyc, acc1_cyc, last_out_cyc;
  logic       prev_gv, prev_stall, gap_en, prev_last;
  logic [8:0] prev_word;
  logic [N-1:0] hs;

  typedef struct {
    logic       ev;
    logic [7:0] ed;
    logic       el;
    logic       egv;
    logic [2:0] egid;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit src_pending();
    for (int k = 0; k < N; k++) if (src_rd[k] < src_wr[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push(input int r, input int len, input logic [7:0] base, input bit term);
    for (int j = 0; j < len; j++) begin
      src_mem[r][src_wr[r] % 64] = {term && (j == len - 1), base + 8'(j)};
      src_wr[r]++;
    end
  endtask

  task automatic exp_pkt(input int len, input logic [7:0] base, input bit term);
    for (int j = 0; j < len; j++) exp_q.push_back({term && (j == len - 1), base + 8'(j)});
  endtask

  // One clock: observe at the falling edge, advance sources just after the rising edge.
  task automatic tick();
    logic [8:0] w;
    hs = '0;
    @(negedge clk);
    if (rstn) begin
      hs = tv & trdy;
      if (hs[1]) acc1_cyc = cyc;
      if (oto) begin
        to_cnt++;
        to_cyc = cyc;
      end
      if (ogv && !prev_gv) grant_log.push_back(int'(ogid));
      if (prev_stall) chk("hold_stable", {54'd0, ovalid, olast, odata}, {54'd0, 1'b1, prev_word});
      if (ovalid && ordy) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_byte: got 0x%0h, want none (cycle %0d)", {olast, odata}, cyc);
        end else begin
          w = exp_q.pop_front();
          chk("out_byte", {55'd0, olast, odata}, {55'd0, w});
        end
        if (gap_en && prev_last) chk("pkt_gap", 64'(cyc - last_out_cyc), 64'd2);
        prev_last    = olast;
        last_out_cyc = cyc;
      end
      prev_stall = ovalid && !ordy;
      prev_word  = {olast, odata};
    end else begin
      prev_stall = 1'b0;
    end
    prev_gv = ogv;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) if (hs[k]) src_rd[k]++;
    cyc++;
  endtask

  task automatic drain(input int max, input string name);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || src_pending()) && i < max) begin
      tick();
      i++;
    end
    chk(name, 64'(exp_q.size() == 0 && !src_pending()), 64'd1);
    repeat (3) tick();
  endtask

  vec_t tbl[6];
  int   rr_exp[6];
  int   to0;
  logic ok;

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0; to_cnt = 0; to_cyc = 0; acc1_cyc = 0; last_out_cyc = 0;
    prev_gv = 0; prev_stall = 0; gap_en = 0; prev_last = 0; prev_word = '0;
    for (int k = 0; k < N; k++) begin
      src_wr[k] = 0;
      src_rd[k] = 0;
    end
    tbl[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd0};
    tbl[2] = '{1'b1, 8'h61, 1'b0, 1'b1, 3'd0};
    tbl[3] = '{1'b1, 8'h62, 1'b0, 1'b1, 3'd0};
    tbl[4] = '{1'b1, 8'h63, 1'b1, 1'b0, 3'd0};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0};
    rr_exp = '{0, 1, 2, 0, 1, 2};

    rstn = 1'b0;
    ordy = 1'b1;
    repeat (2) tick();
    chk("reset_outputs", 64'({ovalid, odata, olast, ogv, ogid, oto, trdy}), 64'd0);
    rstn = 1'b1;
    tick();
    chk("idle_outputs", 64'({ovalid, odata, olast, ogv, ogid, oto, trdy}), 64'd0);

    // "abc" from requester 0, checked cycle by cycle.
    push(0, 3, 8'h61, 1'b1);
    exp_pkt(3, 8'h61, 1'b1);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      chk("abc_tvalid", 64'(ovalid), 64'(tbl[i].ev));
      if (tbl[i].ev) chk("abc_tdata", {55'd0, olast, odata}, {55'd0, tbl[i].el, tbl[i].ed});
      chk("abc_grant_valid", 64'(ogv), 64'(tbl[i].egv));
      if (tbl[i].egv) chk("abc_grant_id", 64'(ogid), 64'(tbl[i].egid));
    end
    drain(20, "abc_done");

    // Requester 3 under toggling backpressure.
    grant_log.delete();
    to0 = to_cnt;
    push(3, 4, 8'hA0, 1'b1);
    exp_pkt(4, 8'hA0, 1'b1);
    for (int i = 0; i < 60 && (exp_q.size() != 0 || src_pending()); i++) begin
      ordy = (i % 3 == 0);
      tick();
    end
    chk("toggle_done", 64'(exp_q.size()), 64'd0);
    chk("toggle_no_timeout", 64'(to_cnt - to0), 64'd0);
    ordy = 1'b1;
    repeat (3) tick();
    chk("toggle_grants", 64'(grant_log.size()), 64'd1);
    chk("toggle_gid", 64'(grant_log[0]), 64'd3);

    // Round robin over three continuously busy requesters.
    grant_log.delete();
    gap_en    = 1'b1;
    prev_last = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < 2; p++) push(r, 2, 8'(16 * (r + 1) + 2 * p), 1'b1);
    end
    for (int p = 0; p < 2; p++) begin
      for (int r = 0; r < 3; r++) exp_pkt(2, 8'(16 * (r + 1) + 2 * p), 1'b1);
    end
    drain(100, "rr_done");
    gap_en = 1'b0;
    chk("rr_grants", 64'(grant_log.size()), 64'd6);
    for (int i = 0; i < 6; i++) chk("rr_order", 64'(grant_log[i]), 64'(rr_exp[i]));

    // Requester 1 stalls mid-packet; requester 2 waits.
    grant_log.delete();
    to0 = to_cnt;
    push(1, 1, 8'hC0, 1'b0);
    push(2, 2, 8'hD0, 1'b1);
    exp_pkt(1, 8'hC0, 1'b0);
    exp_pkt(2, 8'hD0, 1'b1);
    drain(80, "timeout_done");
    chk("timeout_pulses", 64'(to_cnt - to0), 64'd1);
    chk("timeout_latency", 64'(to_cyc - acc1_cyc), 64'(TO));
    chk("timeout_grants", 64'(grant_log.size()), 64'd2);
    chk("timeout_gid0", 64'(grant_log[0]), 64'd1);
    chk("timeout_gid1", 64'(grant_log[1]), 64'd2);

    // Requester 1 keeps valid high while downstream stalls for 100 cycles.
    ordy = 1'b0;
    to0  = to_cnt;
    push(1, 2, 8'h90, 1'b1);
    exp_pkt(2, 8'h90, 1'b1);
    repeat (3) tick();
    ok = 1'b1;
    repeat (100) begin
      tick();
      ok = ok && ogv && (ogid == 3'd1) && tv[1];
    end
    chk("stall_grant_kept", 64'(ok), 64'd1);
    chk("stall_no_timeout", 64'(to_cnt - to0), 64'd0);
    ordy = 1'b1;
    drain(20, "stall_done");

    // Asynchronous reset in the middle of a requester 0 packet.
    grant_log.delete();
    push(0, 6, 8'hE0, 1'b1);
    exp_pkt(6, 8'hE0, 1'b1);
    repeat (4) tick();
    chk("pre_reset_busy", 64'({ovalid, ogv}), 64'd3);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_reset_outputs", 64'({ovalid, odata, olast, ogv, ogid, oto, trdy}), 64'd0);
    for (int k = 0; k < N; k++) src_rd[k] = src_wr[k];
    exp_q.delete();
    tick();
    tick();
    #2;
    rstn = 1'b1;
    grant_log.delete();
    push(1, 1, 8'h71, 1'b1);
    push(0, 1, 8'h70, 1'b1);
    exp_pkt(1, 8'h70, 1'b1);
    exp_pkt(1, 8'h71, 1'b1);
    drain(30, "post_reset_done");
    chk("post_reset_grants", 64'(grant_log.size()), 64'd2);
    chk("post_reset_first", 64'(grant_log[0]), 64'd0);
    chk("post_reset_second", 64'(grant_log[1]), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Packet-level round-robin arbiter that shares one UART TX byte stream among N_REQ requesters. Each requester presents a valid/ready byte stream with an end-of-packet flag. The arbiter locks the grant for a whole packet, then moves to the next requester. Its registered output drives the i_tvalid/i_tdata/i_tlast/i_tready interface of the uart_tx instance, so packets from different sources never interleave on the wire.

Parameters:
N_REQ, 4, number of requesters (2..8)
IDLE_TIMEOUT, 2700000, cycles a granted requester may stall mid-packet before the grant is revoked (0 = never revoke)

Ports:
rstn  input  1  asynchronous active-low reset
clk  input  1  clock; all logic on posedge
i_tvalid  input  N_REQ  per-requester byte valid
i_tready  output  N_REQ  per-requester byte accepted
i_tdata  input  8*N_REQ  requester k byte at [8k+7:8k]
i_tlast  input  N_REQ  byte is last of packet
o_tvalid  output  1  byte valid toward uart_tx
o_tready  input  1  uart_tx ready
o_tdata  output  8  byte toward uart_tx
o_tlast  output  1  last of packet toward uart_tx
o_grant_valid  output  1  a requester currently holds the grant
o_grant_id  output  3  index of the granted requester
o_timeout  output  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE; o_tvalid=0, o_tdata=0, o_tlast=0, i_tready=0, o_grant_valid=0, o_grant_id=0, o_timeout=0, last_grant=N_REQ-1, idle counter=0. A reset mid-packet drops the rest of the packet. The output register is cleared and nothing is replayed.
- Output register: one stage. It may load when `load_ok = !o_tvalid || o_tready`. When o_tvalid=1 and o_tready=0, o_tdata and o_tlast hold stable.
- State IDLE:
  - i_tready=0.
  - If any i_tvalid is set, search round-robin starting at last_grant+1 (mod N_REQ) and pick the first k with i_tvalid[k]=1.
  - Next cycle: state=XFER, o_grant_id=k, o_grant_valid=1, idle counter=0.
  - If no request is present, stay in IDLE.
- State XFER, granted requester g:
  - i_tready[g] = load_ok; all other i_tready bits = 0.
  - On i_tvalid[g] && i_tready[g], on the next edge: o_tdata=byte, o_tlast=i_tlast[g], o_tvalid=1. Latency is 1 cycle. Full throughput is one byte per cycle when o_tready is held at 1.
  - If the accepted byte has tlast=1: on the same edge state=IDLE, last_grant=g, o_grant_valid=0. The earliest next grant starts 1 cycle later, with one IDLE cycle between packets.
  - Idle counter: reset to 0 on every accepted byte. Increment on cycles where i_tvalid[g]=0. Hold while i_tvalid[g]=1 but backpressured, since downstream stall is not the requester's fault.
  - If IDLE_TIMEOUT!=0 and the counter reaches IDLE_TIMEOUT-1 while incrementing: state=IDLE, last_grant=g, o_grant_valid=0, o_timeout=1 for one cycle. The truncated packet is not terminated, and o_tlast is not forced.
- If o_tvalid=0 and o_tready=1, nothing happens. If o_tvalid=1 and o_tready=1 with no new load, o_tvalid drops to 0 next cycle.
- A requester that deasserts i_tvalid without a handshake loses nothing. Only bytes with a handshake are transferred.
- i_tdata and i_tlast of non-granted requesters are ignored.
- A simultaneous tlast acceptance and timeout expiry cannot occur, because an accept clears the counter. Acceptance wins and o_timeout stays 0.
- Fairness: a requester with a continuously pending packet is granted within N_REQ-1 other packets.
- o_grant_id width is fixed at 3; values >= N_REQ never occur.

Test Plan:
- Single requester 0 sends "abc" (tlast on 'c'), o_tready=1 -> o_tdata 0x61,0x62,0x63 on 3 consecutive cycles starting 1 cycle after first accept; o_tlast=1 only with 0x63; o_grant_id=0.
- Requesters 0,1,2 each continuously send 2-byte packets, N_REQ=4 -> packets appear in grant order 0,1,2,0,1,2; packets never interleave; one idle cycle between packets.
- Requester 3 sends 4 bytes while o_tready toggles 1,0,0,1... -> o_tdata/o_tlast stable while o_tready=0; all 4 bytes delivered in order, none lost or duplicated; idle counter never increments.
- IDLE_TIMEOUT=16; requester 1 sends 1 byte without tlast then drops i_tvalid -> o_timeout pulses once, 16 cycles after the last accept; grant passes to requester 2, which has a pending request.
- rstn pulled low asynchronously mid-packet -> all outputs 0 immediately; after release, a pending requester 0 is granted first (last_grant=N_REQ-1).
- Same as the timeout scenario, but requester holds i_tvalid=1 with o_tready=0 for 100 cycles -> no timeout; grant retained.
